// File: rtl/vec_pkg.sv
// Shared types, default widths and the saturation helper for the vector ALU pipeline.
package vec_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_SCALE = 2'd1,
        OP_DOT   = 2'd2,
        OP_RSVD  = 2'd3
    } vec_op_t;

    localparam int DEF_WIDTH     = 24;
    localparam int DEF_FRAC_BITS = 12;
    localparam int SAT_W         = 64;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_clamp(
        input  logic signed [SAT_W-1:0] val,
        input  int                      w,
        output logic                    clipped
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v     = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v     = -(64'sd1 <<< (w - 1));
        clipped   = 1'b0;
        sat_clamp = val;
        if (val > max_v) begin
            sat_clamp = max_v;
            clipped   = 1'b1;
        end else if (val < min_v) begin
            sat_clamp = min_v;
            clipped   = 1'b1;
        end
    endfunction

endpackage

// File: rtl/vec_lane_mul.sv
// One lane of the S2 stage: fixed-point multiply, floor shift, saturate and flag.
module vec_lane_mul
    import vec_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] prod_q,
    output logic                    sat_q
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    b_ext;
    logic signed [PW-1:0]    full;
    logic signed [PW-1:0]    shifted;
    logic signed [WIDTH-1:0] prod_d;
    logic                    sat_d;

    always_comb begin
        a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext   = {{WIDTH{b[WIDTH-1]}}, b};
        full    = a_ext * b_ext;
        shifted = full >>> FRAC_BITS;
        prod_d  = WIDTH'(sat_clamp({{(SAT_W - PW){shifted[PW-1]}}, shifted}, WIDTH, sat_d));
    end

    always_ff @(posedge clk) begin
        if (load) begin
            prod_q <= prod_d;
            sat_q  <= sat_d;
        end
    end

endmodule

// File: rtl/vec_alu_pipe.sv
// Three-stage saturating fixed-point vector ALU (multiply, scale, dot) with
// valid/ready handshake and a tag carried alongside each result.
module vec_alu_pipe
    import vec_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int LANES     = 3,
    parameter int TAG_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic [LANES*WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_sat
);

    localparam int VW    = LANES * WIDTH;
    localparam int SUM_W = WIDTH + $clog2(LANES) + 1;

    logic                    s1_valid_q, s1_valid_d;
    vec_op_t                 s1_op_q, s1_op_d;
    logic [VW-1:0]           s1_a_q, s1_a_d;
    logic [VW-1:0]           s1_b_q, s1_b_d;
    logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;
    logic                    s2_valid_q, s2_valid_d;
    vec_op_t                 s2_op_q, s2_op_d;
    logic [TAG_W-1:0]        s2_tag_q, s2_tag_d;
    logic                    out_valid_q, out_valid_d;
    logic [VW-1:0]           out_data_q, out_data_d;
    logic [TAG_W-1:0]        out_tag_q, out_tag_d;
    logic                    out_sat_q, out_sat_d;

    logic                    s1_load, s2_load, s3_load;
    logic [VW-1:0]           lane_b;
    logic [VW-1:0]           lane_prod;
    logic [LANES-1:0]        lane_sat;
    logic signed [SUM_W-1:0] dot_sum;
    logic signed [WIDTH-1:0] dot_res;
    logic                    dot_sat;

    // A stage loads when it is empty or its occupant leaves this cycle.
    always_comb begin
        s3_load = !out_valid_q || out_ready;
        s2_load = !s2_valid_q || s3_load;
        s1_load = !s1_valid_q || s2_load;
    end

    assign in_ready = rst && s1_load;

    always_comb begin
        lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_b[i*WIDTH +: WIDTH] = (s1_op_q == OP_SCALE) ? s1_b_q[WIDTH-1:0]
                                                             : s1_b_q[i*WIDTH +: WIDTH];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vec_lane_mul #(
            .WIDTH     (WIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_mul (
            .clk    (clk),
            .load   (s2_load),
            .a      (s1_a_q[g*WIDTH +: WIDTH]),
            .b      (lane_b[g*WIDTH +: WIDTH]),
            .prod_q (lane_prod[g*WIDTH +: WIDTH]),
            .sat_q  (lane_sat[g])
        );
    end

    // The dot sum is built from already-clamped lane products, then clamped again.
    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            dot_sum = dot_sum + SUM_W'($signed(lane_prod[i*WIDTH +: WIDTH]));
        end
        dot_res = WIDTH'(sat_clamp(SAT_W'(dot_sum), WIDTH, dot_sat));
    end

    always_comb begin
        s1_valid_d  = s1_load ? in_valid : s1_valid_q;
        s1_op_d     = s1_load ? vec_op_t'(in_op) : s1_op_q;
        s1_a_d      = s1_load ? in_a : s1_a_q;
        s1_b_d      = s1_load ? in_b : s1_b_q;
        s1_tag_d    = s1_load ? in_tag : s1_tag_q;
        s2_valid_d  = s2_load ? s1_valid_q : s2_valid_q;
        s2_op_d     = s2_load ? s1_op_q : s2_op_q;
        s2_tag_d    = s2_load ? s1_tag_q : s2_tag_q;
        out_valid_d = s3_load ? s2_valid_q : out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_sat_d   = out_sat_q;
        if (s3_load && s2_valid_q) begin
            out_tag_d = s2_tag_q;
            if (s2_op_q == OP_DOT) begin
                out_data_d              = '0;
                out_data_d[WIDTH-1:0]   = dot_res;
                out_sat_d               = (|lane_sat) || dot_sat;
            end else begin
                out_data_d = lane_prod;
                out_sat_d  = |lane_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_sat_q   <= out_sat_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_op_q  <= s1_op_d;
        s1_a_q   <= s1_a_d;
        s1_b_q   <= s1_b_d;
        s1_tag_q <= s1_tag_d;
        s2_op_q  <= s2_op_d;
        s2_tag_q <= s2_tag_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_sat   = out_sat_q;

endmodule
